// File: rtl/ctrl_pulse_sync_mc.sv
// ctrl_pulse_sync_mc: per-channel pulse queue delivering tick-aligned, gap-separated pulses to sample_tick logic
module ctrl_pulse_sync_mc #(
  parameter int NUM_CH = 4,
  parameter int HOLD_TICKS = 2,
  parameter int MAX_PEND = 3,
  localparam int PW = $clog2(MAX_PEND + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sample_tick,
  input  logic [NUM_CH-1:0]    pulse_in,
  input  logic [NUM_CH-1:0]    clr_overflow,
  output logic [NUM_CH-1:0]    pulse_out,
  output logic [NUM_CH-1:0]    busy,
  output logic [NUM_CH-1:0]    overflow,
  output logic [NUM_CH*PW-1:0] pend_cnt
);
  localparam int HW = HOLD_TICKS > 1 ? $clog2(HOLD_TICKS) : 1;
  localparam logic [PW-1:0] PMAX = PW'(MAX_PEND);
  localparam logic [HW-1:0] HINIT = HW'(HOLD_TICKS - 1);
  typedef enum logic [1:0] {IDLE, ARMED, HOLD, GAP} state_t;
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    state_t state;
    logic [PW-1:0] pend;
    logic [HW-1:0] hold_cnt;
    logic prev, po, ovf, evt, deq;
    always_comb begin
      evt = pulse_in[c] & ~prev;
      deq = state == IDLE && pend != '0;
    end
    // a simultaneous event and dequeue cancel, so a full queue cannot overflow that cycle
    always_ff @(posedge clk)
      if (rst) begin
        state <= IDLE;
        pend <= '0;
        hold_cnt <= '0;
        prev <= 1'b0;
        po <= 1'b0;
        ovf <= 1'b0;
      end else begin
        prev <= pulse_in[c];
        pend <= (evt && !deq && pend != PMAX) ? pend + 1'b1 : (!evt && deq) ? pend - 1'b1 : pend;
        ovf <= (evt && !deq && pend == PMAX) ? 1'b1 : clr_overflow[c] ? 1'b0 : ovf;
        case (state)
          IDLE: if (deq) state <= ARMED;
          ARMED:
            if (sample_tick) begin
              state <= HOLD;
              po <= 1'b1;
              hold_cnt <= HINIT;
            end
          HOLD:
            if (sample_tick) begin
              if (hold_cnt == '0) begin
                state <= GAP;
                po <= 1'b0;
              end else hold_cnt <= hold_cnt - 1'b1;
            end
          GAP: if (sample_tick) state <= IDLE;
        endcase
      end
    assign pulse_out[c] = po;
    assign overflow[c] = ovf;
    assign busy[c] = state != IDLE || pend != '0;
    assign pend_cnt[c*PW +: PW] = pend;
  end
endmodule

// File: tb/tb_ctrl_pulse_sync_mc.sv
// tb_ctrl_pulse_sync_mc: scoreboard bench; ticks land on posedges that are multiples of 16
module tb_ctrl_pulse_sync_mc;
  localparam int NUM_CH = 4;
  localparam int PW = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sample_tick = 1'b0;
  logic [NUM_CH-1:0] pulse_in = '0;
  logic [NUM_CH-1:0] clr_overflow = '0;
  logic [NUM_CH-1:0] pulse_out, busy, overflow;
  logic [NUM_CH*PW-1:0] pend_cnt;
  int cyc = 0;
  int total = 0;
  int bad = 0;
  typedef struct {
    int rise;
    int width;
  } exp_t;
  exp_t q[NUM_CH][$];
  int rise_at[NUM_CH];
  logic [NUM_CH-1:0] prev_po = '0;

  ctrl_pulse_sync_mc dut (
    .clk(clk),
    .rst(rst),
    .sample_tick(sample_tick),
    .pulse_in(pulse_in),
    .clr_overflow(clr_overflow),
    .pulse_out(pulse_out),
    .busy(busy),
    .overflow(overflow),
    .pend_cnt(pend_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(negedge clk);
    sample_tick = ((cyc + 1) % 16) == 0;
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %0d want %0d", name, cyc, act, exp);
    end
  endtask

  task automatic at(input int c);
    do @(negedge clk); while (cyc < c);
    if (cyc != c) chk("schedule", cyc, c);
  endtask

  task automatic pulse(input int ch, input int c);
    at(c);
    pulse_in[ch] = 1'b1;
    at(c + 1);
    pulse_in[ch] = 1'b0;
  endtask

  task automatic expect_pulse(input int ch, input int rise, input int width);
    exp_t e;
    e.rise = rise;
    e.width = width;
    q[ch].push_back(e);
  endtask

  function automatic int pend(input int ch);
    return int'(pend_cnt[ch*PW +: PW]);
  endfunction

  // monitor: every completed output pulse is matched against the expected queue
  always @(negedge clk)
    if (cyc >= 2) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (pulse_out[ch] && !prev_po[ch]) rise_at[ch] = cyc;
        if (!pulse_out[ch] && prev_po[ch]) begin
          if (q[ch].size() == 0) chk($sformatf("unexpected pulse ch%0d rise", ch), rise_at[ch], -1);
          else begin
            exp_t e;
            e = q[ch].pop_front();
            chk($sformatf("rise ch%0d", ch), rise_at[ch], e.rise);
            chk($sformatf("width ch%0d", ch), cyc - rise_at[ch], e.width);
          end
        end
      end
      prev_po = pulse_out;
    end

  initial begin
    // reset state
    at(2);
    chk("rst pulse_out", int'(pulse_out), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst overflow", int'(overflow), 0);
    chk("rst pend_cnt", int'(pend_cnt), 0);
    at(3);
    rst = 1'b0;
    // single pulse, event two cycles before a tick
    expect_pulse(0, 32, 32);
    pulse(0, 29);
    chk("t1 pend", pend(0), 1);
    at(31);
    chk("t1 pend deq", pend(0), 0);
    chk("t1 busy", int'(busy[0]), 1);
    at(79);
    chk("t1 busy gap", int'(busy[0]), 1);
    at(80);
    chk("t1 busy clr", int'(busy[0]), 0);
    // three queued pulses
    expect_pulse(0, 112, 32);
    expect_pulse(0, 176, 32);
    expect_pulse(0, 240, 32);
    pulse(0, 100);
    pulse(0, 102);
    pulse(0, 104);
    at(106);
    chk("t2 pend2", pend(0), 2);
    at(170);
    chk("t2 pend1", pend(0), 1);
    at(230);
    chk("t2 pend0", pend(0), 0);
    chk("t2 overflow", int'(overflow[0]), 0);
    at(287);
    chk("t2 busy", int'(busy[0]), 1);
    at(288);
    chk("t2 busy clr", int'(busy[0]), 0);
    // overflow with five pulses, then clear and set/clear collision
    expect_pulse(0, 304, 32);
    expect_pulse(0, 368, 32);
    expect_pulse(0, 432, 32);
    expect_pulse(0, 496, 32);
    pulse(0, 290);
    pulse(0, 292);
    pulse(0, 294);
    pulse(0, 296);
    at(298);
    chk("t3 ovf before", int'(overflow[0]), 0);
    pulse_in[0] = 1'b1;
    at(299);
    pulse_in[0] = 1'b0;
    chk("t3 ovf set", int'(overflow[0]), 1);
    chk("t3 pend full", pend(0), 3);
    at(300);
    clr_overflow[0] = 1'b1;
    at(301);
    clr_overflow[0] = 1'b0;
    chk("t3 ovf clr", int'(overflow[0]), 0);
    at(310);
    pulse_in[0] = 1'b1;
    clr_overflow[0] = 1'b1;
    at(311);
    pulse_in[0] = 1'b0;
    clr_overflow[0] = 1'b0;
    chk("t3 set wins", int'(overflow[0]), 1);
    chk("t3 pend held", pend(0), 3);
    at(320);
    clr_overflow[0] = 1'b1;
    at(321);
    clr_overflow[0] = 1'b0;
    chk("t3 ovf clr2", int'(overflow[0]), 0);
    at(544);
    chk("t3 busy clr", int'(busy[0]), 0);
    // level-held input gives one event
    expect_pulse(0, 576, 32);
    at(560);
    pulse_in[0] = 1'b1;
    at(600);
    chk("t4 pend", pend(0), 0);
    at(660);
    pulse_in[0] = 1'b0;
    at(700);
    chk("t4 busy", int'(busy[0]), 0);
    // reset during HOLD drops everything
    expect_pulse(0, 720, 11);
    pulse(0, 704);
    pulse(0, 706);
    pulse(0, 708);
    at(710);
    chk("t5 pend", pend(0), 2);
    at(725);
    chk("t5 high", int'(pulse_out[0]), 1);
    at(730);
    rst = 1'b1;
    at(731);
    rst = 1'b0;
    chk("t5 pulse_out", int'(pulse_out), 0);
    chk("t5 pend", int'(pend_cnt), 0);
    chk("t5 busy", int'(busy), 0);
    at(790);
    chk("t5 idle", int'(busy), 0);
    // independent channels on a shared tick
    expect_pulse(0, 816, 32);
    expect_pulse(1, 816, 32);
    expect_pulse(1, 880, 32);
    expect_pulse(2, 816, 32);
    expect_pulse(3, 832, 32);
    pulse(0, 800);
    at(812);
    pulse_in = 4'b0010;
    at(813);
    pulse_in = 4'b0100;
    at(814);
    pulse_in = 4'b1000;
    at(815);
    pulse_in = 4'b0000;
    pulse(1, 820);
    at(822);
    chk("t6 pend_cnt", int'(pend_cnt), 4);
    chk("t6 busy", int'(busy), 15);
    at(960);
    chk("t6 busy clr", int'(busy), 0);
    for (int ch = 0; ch < NUM_CH; ch++) chk($sformatf("missing pulses ch%0d", ch), q[ch].size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
